// File: rtl/mem_access_stage.sv
// MIPS MEM stage: word-addressed data RAM with MEM_LAT-cycle loads/stores,
// upstream stall via holdreg, and the MEM/WB output register.
module mem_access_stage #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned MEM_LAT = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  control_signals,
   input  logic [4:0]  inst20to16,
   input  logic [4:0]  inst15to11,
   input  logic [31:0] aluresult,
   input  logic [31:0] readdata2,
   input  logic [31:0] newpc,
   output logic        holdreg,
   output logic        wb_regwrite,
   output logic [4:0]  wb_dest,
   output logic [31:0] wb_data,
   output logic        mem_err
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT   = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        complete;
   logic        hold_raw;

   logic [31:0] ram [DEPTH];
   logic [AW-1:0] idx;
   logic        mem_read, mem_write, mem_op, acc_err;
   logic [31:0] rdata;
   logic [4:0]  dest_sel;
   logic [31:0] data_sel;

   assign mem_read  = control_signals[1];
   // Read wins when both strobes are set, so such an op never writes.
   assign mem_write = control_signals[0] & ~control_signals[1];
   assign mem_op    = control_signals[1] | control_signals[0];
   assign acc_err   = (aluresult[1:0] != 2'b00) || (aluresult >= ADDR_LIMIT);
   assign idx       = aluresult[AW+1:2];
   assign rdata     = acc_err ? '0 : ram[idx];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      hold_raw = 1'b0;
      complete = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!mem_op || MEM_LAT == 1) begin
               complete = 1'b1;
            end else begin
               hold_raw = 1'b1;
               cnt_nx   = CNT_INIT;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt != 4'd0) begin
               hold_raw = 1'b1;
               cnt_nx   = cnt - 4'd1;
            end else begin
               complete = 1'b1;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign holdreg = hold_raw & rst_n;

   always_comb begin
      dest_sel = inst20to16;
      unique case (control_signals[6:5])
         2'b01:   dest_sel = inst15to11;
         2'b10:   dest_sel = 5'd31;
         default: dest_sel = inst20to16;
      endcase
      data_sel = aluresult;
      unique case (control_signals[4:3])
         2'b01:   data_sel = rdata;
         2'b10:   data_sel = newpc;
         default: data_sel = aluresult;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         wb_regwrite <= 1'b0;
         wb_dest     <= '0;
         wb_data     <= '0;
         mem_err     <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (complete) begin
            wb_regwrite <= control_signals[2];
            wb_dest     <= dest_sel;
            wb_data     <= data_sel;
            if (mem_op && acc_err)
               mem_err <= 1'b1;
         end else begin
            wb_regwrite <= 1'b0;
            wb_dest     <= '0;
            wb_data     <= '0;
         end
      end
   end

   // RAM is not reset; rst_n gating keeps an in-reset edge from writing.
   always_ff @(posedge clk) begin
      if (rst_n && complete && mem_write && !acc_err)
         ram[idx] <= readdata2;
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: one DUT at MEM_LAT=3, one at MEM_LAT=1.
module tb_mem_access_stage;

   localparam int unsigned DEPTH = 256;

   typedef struct {
      int          cyc;
      logic [4:0]  dest;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [6:0]  ctrl [2];
   logic [4:0]  rt   [2];
   logic [4:0]  rd   [2];
   logic [31:0] alu  [2];
   logic [31:0] wdat [2];
   logic [31:0] npc  [2];

   logic        hold0, wr0, err0, hold1, wr1, err1;
   logic [4:0]  dest0, dest1;
   logic [31:0] data0, data1;

   exp_t q0[$];
   exp_t q1[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_stage #(.DEPTH(DEPTH), .MEM_LAT(3)) dut0 (
      .clk(clk), .rst_n(rst_n), .control_signals(ctrl[0]),
      .inst20to16(rt[0]), .inst15to11(rd[0]), .aluresult(alu[0]),
      .readdata2(wdat[0]), .newpc(npc[0]), .holdreg(hold0),
      .wb_regwrite(wr0), .wb_dest(dest0), .wb_data(data0), .mem_err(err0)
   );

   mem_access_stage #(.DEPTH(DEPTH), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .control_signals(ctrl[1]),
      .inst20to16(rt[1]), .inst15to11(rd[1]), .aluresult(alu[1]),
      .readdata2(wdat[1]), .newpc(npc[1]), .holdreg(hold1),
      .wb_regwrite(wr1), .wb_dest(dest1), .wb_data(data1), .mem_err(err1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic compare_entry(input string tag, input exp_t e, input logic [4:0] d,
                                input logic [31:0] v);
      check({tag, "_cycle"}, cyc, e.cyc);
      check({tag, "_dest"}, {27'd0, d}, {27'd0, e.dest});
      check({tag, "_data"}, v, e.data);
   endtask

   // Monitors: every MEM/WB entry with RegWrite set must match the next queued expectation.
   always @(negedge clk) begin
      if (wr0 === 1'b1) begin
         if (q0.size() == 0) check("dut0_unexpected_wb", {27'd0, dest0}, 32'hFFFF_FFFF);
         else compare_entry("dut0_wb", q0.pop_front(), dest0, data0);
      end
   end

   always @(negedge clk) begin
      if (wr1 === 1'b1) begin
         if (q1.size() == 0) check("dut1_unexpected_wb", {27'd0, dest1}, 32'hFFFF_FFFF);
         else compare_entry("dut1_wb", q1.pop_front(), dest1, data1);
      end
   end

   task automatic idle(input int d);
      ctrl[d] = '0; rt[d] = '0; rd[d] = '0; alu[d] = '0; wdat[d] = '0; npc[d] = '0;
   endtask

   // Present one instruction at d's EX/MEM output, queue its expected writeback,
   // and check holdreg on every cycle it occupies the stage.
   task automatic issue(input int d, input logic [6:0] c, input logic [4:0] t,
                        input logic [4:0] r, input logic [31:0] a, input logic [31:0] w,
                        input logic [31:0] p, input logic [4:0] ed, input logic [31:0] ev);
      int   lat;
      exp_t e;
      lat = (c[1] | c[0]) ? ((d == 0) ? 3 : 1) : 1;
      ctrl[d] = c; rt[d] = t; rd[d] = r; alu[d] = a; wdat[d] = w; npc[d] = p;
      if (c[2]) begin
         e.cyc = cyc + lat; e.dest = ed; e.data = ev;
         if (d == 0) q0.push_back(e);
         else q1.push_back(e);
      end
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         check((d == 0) ? "dut0_holdreg" : "dut1_holdreg",
               {31'd0, (d == 0) ? hold0 : hold1}, {31'd0, (k < lat - 1)});
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      idle(0); idle(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_holdreg", {31'd0, hold0}, 32'd0);
      check("rst_wr", {31'd0, wr0}, 32'd0);
      check("rst_dest", {27'd0, dest0}, 32'd0);
      check("rst_data", data0, 32'd0);
      check("rst_err", {31'd0, err0}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // MEM_LAT = 3
      issue(0, 7'b0100100, 5'd0, 5'd7, 32'h1234, 32'h0, 32'h0, 5'd7, 32'h1234);
      issue(0, 7'b0000001, 5'd0, 5'd0, 32'h10, 32'hDEAD_BEEF, 32'h0, 5'd0, 32'h0);
      issue(0, 7'b0001110, 5'd9, 5'd0, 32'h10, 32'h0, 32'h0, 5'd9, 32'hDEAD_BEEF);
      issue(0, 7'b1010100, 5'd0, 5'd0, 32'h0, 32'h0, 32'h400, 5'd31, 32'h400);
      issue(0, 7'b1111100, 5'd3, 5'd4, 32'h77, 32'h0, 32'h0, 5'd3, 32'h77);
      issue(0, 7'b0000001, 5'd0, 5'd0, 32'h20, 32'hCAFE_0000, 32'h0, 5'd0, 32'h0);
      issue(0, 7'b0000001, 5'd0, 5'd0, 32'h0, 32'h0BAD_F00D, 32'h0, 5'd0, 32'h0);
      idle(0);
      check("err_clear_before_fault", {31'd0, err0}, 32'd0);
      issue(0, 7'b0001110, 5'd10, 5'd0, 32'h13, 32'h0, 32'h0, 5'd10, 32'h0);
      idle(0);
      check("err_after_misaligned", {31'd0, err0}, 32'd1);
      // Out-of-range store aliases to word 0 if the range check is missing.
      issue(0, 7'b0000001, 5'd0, 5'd0, 32'(4 * DEPTH), 32'h5555_5555, 32'h0, 5'd0, 32'h0);
      issue(0, 7'b0001110, 5'd11, 5'd0, 32'h0, 32'h0, 32'h0, 5'd11, 32'h0BAD_F00D);
      issue(0, 7'b0001111, 5'd12, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd12, 32'h0BAD_F00D);
      issue(0, 7'b0001110, 5'd13, 5'd0, 32'h0, 32'h0, 32'h0, 5'd13, 32'h0BAD_F00D);
      issue(0, 7'b0100100, 5'd0, 5'd14, 32'h99, 32'h0, 32'h0, 5'd14, 32'h99);
      idle(0);
      check("err_sticky", {31'd0, err0}, 32'd1);

      // MEM_LAT = 1: fill four words, then four back-to-back loads
      issue(1, 7'b0000001, 5'd0, 5'd0, 32'h0, 32'h1, 32'h0, 5'd0, 32'h0);
      issue(1, 7'b0000001, 5'd0, 5'd0, 32'h4, 32'h22, 32'h0, 5'd0, 32'h0);
      issue(1, 7'b0000001, 5'd0, 5'd0, 32'h8, 32'h333, 32'h0, 5'd0, 32'h0);
      issue(1, 7'b0000001, 5'd0, 5'd0, 32'hC, 32'h4444, 32'h0, 5'd0, 32'h0);
      issue(1, 7'b0001110, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0, 5'd1, 32'h1);
      issue(1, 7'b0001110, 5'd2, 5'd0, 32'h4, 32'h0, 32'h0, 5'd2, 32'h22);
      issue(1, 7'b0001110, 5'd3, 5'd0, 32'h8, 32'h0, 32'h0, 5'd3, 32'h333);
      issue(1, 7'b0001110, 5'd4, 5'd0, 32'hC, 32'h0, 32'h0, 5'd4, 32'h4444);
      idle(1);
      check("dut1_err", {31'd0, err1}, 32'd0);

      // Reset pulse during WAIT of a store to 0x20
      ctrl[0] = 7'b0000001; alu[0] = 32'h20; wdat[0] = 32'h1111_1111;
      @(negedge clk);
      check("abort_hold_first", {31'd0, hold0}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("abort_holdreg", {31'd0, hold0}, 32'd0);
      check("abort_wr", {31'd0, wr0}, 32'd0);
      check("abort_dest", {27'd0, dest0}, 32'd0);
      check("abort_data", data0, 32'd0);
      check("abort_err", {31'd0, err0}, 32'd0);
      idle(0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(0, 7'b0001110, 5'd15, 5'd0, 32'h20, 32'h0, 32'h0, 5'd15, 32'hCAFE_0000);
      idle(0);

      repeat (4) @(posedge clk);
      #1;
      check("dut0_queue_drained", q0.size(), 32'd0);
      check("dut1_queue_drained", q1.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register. It holds the word-addressed data RAM and runs loads and stores with a parameterised access latency. While a multi-cycle access is pending it stalls the upstream stages through the EX/MEM hold input. Its output register is the MEM/WB register, carrying the resolved destination register, the selected writeback data and the write enable.

## Interface
- DEPTH, default 256: data RAM size in 32-bit words; power of two, 4..65536.
- MEM_LAT, default 3: cycles a load/store occupies this stage; legal range 1..15.
- clk  in  1: single clock, all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- control_signals  in  7: from EX/MEM.
  - [6:5] RegDst: 00 = rt, 01 = rd, 10 = r31, 11 = rt.
  - [4:3] MemtoReg: 00 = ALU, 01 = memory, 10 = NEWPC, 11 = ALU.
  - [2] RegWrite; [1] MemRead; [0] MemWrite.
- inst20to16  in  5: rt field from EX/MEM.
- inst15to11  in  5: rd field from EX/MEM.
- aluresult  in  32: byte address for memory ops, and ALU writeback value.
- readdata2  in  32: store data.
- newpc  in  32: PC+4, the link value.
- holdreg  out  1: stall request to EX/MEM and earlier stages; combinational.
- wb_regwrite  out  1: MEM/WB RegWrite.
- wb_dest  out  5: MEM/WB destination register number.
- wb_data  out  32: MEM/WB writeback value.
- mem_err  out  1: sticky access-error flag.

## Operation
- Memory op: MemRead or MemWrite set.
  - Both set is legal input and is treated as a read; no write occurs.
- RAM word index: aluresult[log2(DEPTH)+1:2].
- Access error: aluresult[1:0] != 0, or aluresult >= 4*DEPTH.
  - On error: no RAM write; load data is 0; mem_err set at completion and held until reset.
- Destination: wb_dest = RegDst-selected value; r31 = 5'd31.
- Data select:
  - ALU: wb_data = aluresult.
  - memory: wb_data = RAM word, or 0 on error.
  - NEWPC: wb_data = newpc.
- FSM states IDLE and WAIT; down-counter cnt, 4 bits.
  - IDLE, no memory op: MEM/WB loads the incoming instruction; stay IDLE.
  - IDLE, memory op, MEM_LAT = 1: complete the access this cycle; stay IDLE.
  - IDLE, memory op, MEM_LAT > 1: holdreg = 1; MEM/WB loads a bubble (wb_regwrite = 0, wb_dest = 0, wb_data = 0); cnt <= MEM_LAT-2; go to WAIT.
  - WAIT, cnt != 0: holdreg = 1; bubble; cnt decrements.
  - WAIT, cnt == 0: holdreg = 0; complete the access; go to IDLE.
- Completing an access:
  - Store: RAM written on that edge.
  - Load: RAM read in the same cycle; the read is combinational from the index.
  - MEM/WB loads the instruction's writeback fields.
- Each store writes the RAM exactly once. Each instruction produces exactly one non-bubble MEM/WB entry.
- Inputs are stable throughout WAIT because holdreg freezes EX/MEM.

## Timing
- Reset values: state IDLE, cnt 0, wb_regwrite 0, wb_dest 0, wb_data 0, mem_err 0.
  - holdreg is 0 while in reset.
  - RAM contents are not reset.
- Reset asserted mid-access aborts it: no RAM write, no writeback, FSM returns to IDLE.
- Non-memory instruction: MEM/WB valid 1 edge after EX/MEM presents it.
- Memory instruction: MEM/WB valid MEM_LAT edges after EX/MEM presents it.
  - Preceded by MEM_LAT-1 bubble cycles.
  - holdreg high for exactly MEM_LAT-1 cycles.
- Back-to-back memory ops: the second starts in the cycle after completion, with no extra idle cycle.
- A load followed by any instruction reading the same RAM word sees the loaded value. A store followed by a load of the same word returns the stored value.

## Test plan
- Reset then ALU op, ctrl 0100100, inst15to11 = 7, aluresult = 0x1234 -> after 1 edge: wb_regwrite = 1, wb_dest = 7, wb_data = 0x1234; holdreg stays 0.
- MEM_LAT = 3: store ctrl 0000001, addr 0x10, data 0xDEADBEEF; then load ctrl 0001110, rt = 9, addr 0x10.
  - holdreg high 2 cycles per op; 2 bubbles each.
  - Load yields wb_dest = 9, wb_data = 0xDEADBEEF after 3 edges.
- JAL-style ctrl 1010100, newpc = 0x400 -> wb_dest = 31, wb_data = 0x400, 1-cycle latency.
- Misaligned load at addr 0x13, then out-of-range store at 4*DEPTH.
  - Load: wb_data = 0, mem_err = 1 and sticky.
  - Store: RAM unchanged, verified by a later load.
- rst_n pulsed low during WAIT of a store to 0x20 -> outputs 0, holdreg 0, FSM IDLE; a later load of 0x20 returns the prior contents.
- MEM_LAT = 1 with 4 back-to-back loads -> holdreg never asserted; one result per cycle.
